// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_pkg
// Description : Shared SRAM bus widths, controller timing, tester states and
//               the test data pattern.
// Revision    : 1.0
// ============================================================================
package sram_pkg;

  localparam int SRAM_AW       = 15;
  localparam int SRAM_DW       = 8;
  localparam int CTRL_TXN_CYC  = 6;
  localparam int CTRL_RD_VALID = 5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_WAIT = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_DONE    = 3'd5
  } tester_state_t;

  // Low address byte keyed with the seed; cheap to regenerate on readback.
  function automatic logic [SRAM_DW-1:0] pattern(input logic [SRAM_AW-1:0] addr,
                                                 input logic [SRAM_DW-1:0] seed);
    return SRAM_DW'(addr) ^ seed;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_tester.sv
`default_nettype none
// ============================================================================
// Module      : sram_tester
// Description : Writes a keyed pattern over an address window through the
//               SRAM controller, reads it back and reports mismatches.
// Revision    : 1.0
// ============================================================================
module sram_tester
  import sram_pkg::*;
#(
  parameter logic [SRAM_AW-1:0] ADDR_LO = 15'h0000,
  parameter logic [SRAM_AW-1:0] ADDR_HI = 15'h7FFF,
  parameter logic [SRAM_DW-1:0] SEED    = 8'hA5,
  parameter int                 TXN_GAP = CTRL_TXN_CYC + 2,
  parameter int                 RD_LAT  = CTRL_RD_VALID + 1,
  parameter int                 ERR_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               sram_wreq,
  output logic [SRAM_AW-1:0] sram_waddr,
  output logic [SRAM_DW-1:0] sram_wdata,
  output logic               sram_rreq,
  output logic [SRAM_AW-1:0] sram_raddr,
  input  logic [SRAM_DW-1:0] sram_rdata,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_cnt,
  output logic [SRAM_AW-1:0] first_err_addr
);

  localparam logic [7:0] c_wait_end = 8'(TXN_GAP - 2);
  localparam logic [7:0] c_rd_smp   = 8'(RD_LAT - 1);

  tester_state_t      r_state;
  tester_state_t      w_state_nxt;
  logic [7:0]         r_timer;
  logic [7:0]         w_timer_nxt;
  logic [SRAM_AW-1:0] r_addr;
  logic [SRAM_AW-1:0] w_addr_nxt;
  logic               w_clear;
  logic               w_sample;
  logic               w_mismatch;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_addr_nxt  = r_addr;
    w_clear     = 1'b0;
    w_sample    = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_WR_REQ;
          w_addr_nxt  = ADDR_LO;
          w_clear     = 1'b1;
        end
      end
      ST_WR_REQ: begin
        w_timer_nxt = '0;
        w_state_nxt = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        w_timer_nxt = r_timer + 8'd1;
        if (r_timer == c_wait_end) begin
          // Equality before increment keeps ADDR_HI=7FFF from wrapping.
          if (r_addr == ADDR_HI) begin
            w_addr_nxt  = ADDR_LO;
            w_state_nxt = ST_RD_REQ;
          end else begin
            w_addr_nxt  = r_addr + SRAM_AW'(1);
            w_state_nxt = ST_WR_REQ;
          end
        end
      end
      ST_RD_REQ: begin
        w_timer_nxt = '0;
        w_state_nxt = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        w_timer_nxt = r_timer + 8'd1;
        w_sample    = (r_timer == c_rd_smp);
        if (r_timer == c_wait_end) begin
          if (r_addr == ADDR_HI) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_addr_nxt  = r_addr + SRAM_AW'(1);
            w_state_nxt = ST_RD_REQ;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_mismatch = w_sample && (sram_rdata != pattern(r_addr, SEED));

  always_ff @(posedge clk) begin
    if (!rst) begin
      sram_wreq      <= 1'b0;
      sram_waddr     <= '0;
      sram_wdata     <= '0;
      sram_rreq      <= 1'b0;
      sram_raddr     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else begin
      sram_wreq <= (r_state == ST_WR_REQ);
      sram_rreq <= (r_state == ST_RD_REQ);
      if (r_state == ST_WR_REQ) begin
        sram_waddr <= r_addr;
        sram_wdata <= pattern(r_addr, SEED);
      end
      if (r_state == ST_RD_REQ) begin
        sram_raddr <= r_addr;
      end
      busy <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
      done <= (w_state_nxt == ST_DONE);
      if (w_clear) begin
        pass           <= 1'b0;
        err_cnt        <= '0;
        first_err_addr <= '0;
      end else begin
        if (w_mismatch) begin
          if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
          if (err_cnt == '0) first_err_addr <= r_addr;
        end
        // The last compare may land on the same edge as the DONE entry.
        if ((w_state_nxt == ST_DONE) && (r_state != ST_DONE)) begin
          pass <= (err_cnt == '0) && !w_mismatch;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_tester.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_tester
// Description : Directed bench for sram_tester with an ideal SRAM model and
//               a queue of expected write/read requests.
// Revision    : 1.0
// ============================================================================
module tb_sram_tester;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start0, start1, start2;

  logic        wreq0, rreq0, busy0, done0, pass0;
  logic [14:0] waddr0, raddr0, first0;
  logic [7:0]  wdata0, rdata0;
  logic [15:0] err0;

  logic        wreq1, rreq1, busy1, done1, pass1;
  logic [14:0] waddr1, raddr1, first1;
  logic [7:0]  wdata1, rdata1;
  logic [15:0] err1;

  logic        wreq2, rreq2, busy2, done2, pass2;
  logic [14:0] waddr2, raddr2, first2;
  logic [7:0]  wdata2, rdata2;
  logic [1:0]  err2;

  sram_tester #(.ADDR_LO(15'h0000), .ADDR_HI(15'h0003)) dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .sram_wreq(wreq0), .sram_waddr(waddr0), .sram_wdata(wdata0),
    .sram_rreq(rreq0), .sram_raddr(raddr0), .sram_rdata(rdata0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .first_err_addr(first0)
  );

  sram_tester #(.ADDR_LO(15'h7FFF), .ADDR_HI(15'h7FFF)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .sram_wreq(wreq1), .sram_waddr(waddr1), .sram_wdata(wdata1),
    .sram_rreq(rreq1), .sram_raddr(raddr1), .sram_rdata(rdata1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .first_err_addr(first1)
  );

  sram_tester #(.ADDR_LO(15'h0000), .ADDR_HI(15'h0007), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .sram_wreq(wreq2), .sram_waddr(waddr2), .sram_wdata(wdata2),
    .sram_rreq(rreq2), .sram_raddr(raddr2), .sram_rdata(rdata2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .first_err_addr(first2)
  );

  // SRAM models: fault0 1 forces bit0 low, 2 forces bit0 high.
  logic [7:0] mem0 [16];
  logic [7:0] mem1;
  int         fault0;
  always @(posedge clk) if (wreq0) mem0[waddr0[3:0]] <= wdata0;
  always @(posedge clk) if (wreq1) mem1 <= wdata1;
  assign rdata0 = (fault0 == 1) ? (mem0[raddr0[3:0]] & 8'hFE) :
                  (fault0 == 2) ? (mem0[raddr0[3:0]] | 8'h01) : mem0[raddr0[3:0]];
  assign rdata1 = mem1;
  assign rdata2 = 8'h00;

  typedef struct {
    logic [14:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t         wq0[$];
  logic [14:0] rq0[$];
  int total = 0, bad = 0;
  int cyc = 0, last_req0 = -1;
  int exp_err0, exp_first0;
  int n_w1, n_r1;
  logic [7:0] pat_tbl [4] = '{8'hA5, 8'hA4, 8'hA7, 8'hA6};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    wr_t         e;
    logic [14:0] ra;
    @(posedge clk);
    #1;
    cyc++;
    if (wreq0 || rreq0) begin
      check("excl0", 32'(wreq0 & rreq0), 0);
      if (last_req0 >= 0) check("gap0", cyc - last_req0, 8);
      last_req0 = cyc;
    end
    if (wreq0) begin
      check("wq0_pending", 32'(wq0.size() > 0), 1);
      if (wq0.size() > 0) begin
        e = wq0.pop_front();
        check("waddr0", waddr0, e.addr);
        check("wdata0", wdata0, e.data);
      end
    end
    if (rreq0) begin
      check("rq0_pending", 32'(rq0.size() > 0), 1);
      if (rq0.size() > 0) begin
        ra = rq0.pop_front();
        check("raddr0", raddr0, ra);
      end
    end
    if (wreq1) begin
      n_w1++;
      check("waddr1", waddr1, 15'h7FFF);
      check("wdata1", wdata1, 8'h5A);
    end
    if (rreq1) begin
      n_r1++;
      check("raddr1", raddr1, 15'h7FFF);
      check("excl1", 32'(wreq1 & rreq1), 0);
    end
  endtask

  task automatic arm0(input int f);
    logic [7:0] p, obs;
    fault0 = f;
    wq0.delete();
    rq0.delete();
    exp_err0   = 0;
    exp_first0 = 0;
    last_req0  = -1;
    for (int a = 0; a < 4; a++) begin
      p = pat_tbl[a];
      wq0.push_back('{addr: 15'(a), data: p});
      rq0.push_back(15'(a));
      obs = (f == 1) ? (p & 8'hFE) : (f == 2) ? (p | 8'h01) : p;
      if (obs != p) begin
        if (exp_err0 == 0) exp_first0 = a;
        exp_err0++;
      end
    end
  endtask

  task automatic start_run0();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check("start_busy0", busy0, 1);
    check("start_done0", done0, 0);
    check("start_err0", err0, 0);
    check("start_first0", first0, 0);
    check("start_pass0", pass0, 0);
    tick();
    check("wreq0_first", wreq0, 1);
  endtask

  task automatic wait_done0(input int budget);
    int n;
    n = 0;
    while (done0 !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("done0_reached", done0, 1);
  endtask

  task automatic check_results0(input string pfx);
    check({pfx, "_busy"}, busy0, 0);
    check({pfx, "_pass"}, pass0, 32'(exp_err0 == 0));
    check({pfx, "_err"}, err0, exp_err0);
    check({pfx, "_first"}, first0, exp_first0);
    check({pfx, "_wq_left"}, wq0.size(), 0);
    check({pfx, "_rq_left"}, rq0.size(), 0);
  endtask

  task automatic check_idle0(input string pfx);
    check({pfx, "_busy"}, busy0, 0);
    check({pfx, "_done"}, done0, 0);
    check({pfx, "_pass"}, pass0, 0);
    check({pfx, "_err"}, err0, 0);
    check({pfx, "_first"}, first0, 0);
    check({pfx, "_wreq"}, wreq0, 0);
    check({pfx, "_rreq"}, rreq0, 0);
    check({pfx, "_waddr"}, waddr0, 0);
    check({pfx, "_wdata"}, wdata0, 0);
    check({pfx, "_raddr"}, raddr0, 0);
  endtask

  initial begin
    int n;
    rst = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    fault0 = 0;
    n_w1 = 0;
    n_r1 = 0;
    repeat (3) tick();
    check_idle0("reset");
    check("reset_done1", done1, 0);
    check("reset_busy2", busy2, 0);
    rst = 1'b1;
    tick();

    // Clean run, with a start pulse while busy that must be ignored.
    arm0(0);
    start_run0();
    repeat (40) tick();
    check("midrun_busy0", busy0, 1);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    wait_done0(200);
    check_results0("clean");

    // Bit0 stuck low: mismatches at addresses 0 and 2.
    arm0(1);
    start_run0();
    wait_done0(200);
    check_results0("bit0lo");

    // Bit0 stuck high: mismatches at addresses 1 and 3.
    arm0(2);
    start_run0();
    wait_done0(200);
    check_results0("bit0hi");

    // Restart from DONE clears results; then reset during WR_WAIT.
    arm0(0);
    start_run0();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_idle0("midrst");
    wq0.delete();
    rq0.delete();
    last_req0 = -1;
    repeat (30) tick();
    check("post_rst_busy0", busy0, 0);
    check("post_rst_wreq0", wreq0, 0);

    arm0(0);
    start_run0();
    wait_done0(200);
    check_results0("after_rst");

    // Single-address window at the top of the address space.
    n_w1 = 0;
    n_r1 = 0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n = 0;
    while (done1 !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("done1_reached", done1, 1);
    repeat (12) tick();
    check("n_wreq1", n_w1, 1);
    check("n_rreq1", n_r1, 1);
    check("pass1", pass1, 1);
    check("err1", err1, 0);
    check("first1", first1, 0);
    check("raddr1_hold", raddr1, 15'h7FFF);
    check("done1_held", done1, 1);

    // All reads return zero: 2-bit counter saturates.
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    n = 0;
    while (done2 !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check("done2_reached", done2, 1);
    check("err2_sat", err2, 2'd3);
    check("first2", first2, 0);
    check("pass2", pass2, 0);
    check("busy2", busy2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
